// File: rtl/periph_sram_pkg.sv
// Shared types and constants for the peripheral-bus SRAM controller.
// The bus-to-macro bitmask helper also lives here.
package periph_sram_pkg;

  localparam int SRAM_DEPTH = 1024;
  localparam int SRAM_AW    = 10;
  localparam int WORD_W     = 32;
  localparam int BANK_LSB   = 12;
  localparam int BANK_W     = 3;
  localparam int ADDR_W     = 24;
  localparam int BE_W       = WORD_W / 8;

  localparam logic [WORD_W-1:0] ERR_DATA_DEFAULT = 32'hBADC_0DE5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  // Everything the controller drives onto the shared macro bus, minus the per-bank enables.
  typedef struct packed {
    logic [SRAM_AW-1:0] addr;
    logic [WORD_W-1:0]  bm;
    logic [WORD_W-1:0]  din;
    logic               wen;
    logic               ren;
  } sram_bus_t;

  // Request attributes captured at accept and carried to the response.
  typedef struct packed {
    logic              valid;
    logic              err;
    logic              we;
    logic [BANK_W-1:0] bank;
  } rsp_t;

  function automatic logic [WORD_W-1:0] be_to_bm(input logic [BE_W-1:0] be);
    logic [WORD_W-1:0] bm;
    bm = '0;
    for (int i = 0; i < BE_W; i++) begin
      bm[8*i +: 8] = {8{be[i]}};
    end
    return bm;
  endfunction

endpackage

// File: rtl/periph_sram_clear_seq.sv
// Clear engine: walks the word address 0..SRAM_DEPTH-1, one word per cycle,
// and flags the last word so the controller can return to READY.
module periph_sram_clear_seq
  import periph_sram_pkg::*;
#(
  parameter bit BUSY_ON_RESET = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [SRAM_AW-1:0] cnt,
  output logic               busy,
  output logic               done
);

  logic [SRAM_AW-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;

  // NOTE: every variable gets a default at the top of a combinational block,
  // so no branch can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (busy_q) begin
      cnt_d = cnt_q + SRAM_AW'(1);
      if (cnt_q == '1) begin
        busy_d = 1'b0;
      end
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= BUSY_ON_RESET;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign cnt  = cnt_q;
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '1);

endmodule

// File: rtl/periph_sram_ctrl.sv
// Peripheral-bus (REQ/GNT/RVALID) controller for a row of 1024x32 SRAM macros,
// with address decode, error responses and a zero-fill clear engine.
module periph_sram_ctrl
  import periph_sram_pkg::*;
#(
  parameter int                NUM_BANKS      = 7,
  parameter bit                OUT_REG        = 1'b0,
  parameter bit                CLEAR_ON_RESET = 1'b1,
  parameter logic [WORD_W-1:0] ERR_DATA       = ERR_DATA_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req,
  input  logic                        we,
  input  logic [BE_W-1:0]             be,
  input  logic [ADDR_W-1:0]           addr,
  input  logic [WORD_W-1:0]           wdata,
  output logic                        gnt,
  output logic                        rvalid,
  output logic [WORD_W-1:0]           rdata,
  output logic                        err,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic [SRAM_AW-1:0]          sram_addr,
  output logic [WORD_W-1:0]           sram_bm,
  output logic [WORD_W-1:0]           sram_din,
  output logic                        sram_wen,
  output logic                        sram_ren,
  output logic [NUM_BANKS-1:0]        sram_men,
  input  logic [NUM_BANKS*WORD_W-1:0] sram_dout
);

  state_e state_q, state_d;

  logic [SRAM_AW-1:0] clr_cnt;
  logic               clr_busy;
  logic               clr_done;
  logic               clr_start;

  logic               accept;
  logic               mapped;
  logic [SRAM_AW-1:0] req_word;
  logic [BANK_W-1:0]  req_bank;
  logic               unused_addr_lsbs;

  sram_bus_t          bus_q, bus_d;
  logic [NUM_BANKS-1:0] men_c;

  rsp_t               rsp_q, rsp_d;
  logic [WORD_W-1:0]  rd_bank;
  logic               out_valid_d;
  logic [WORD_W-1:0]  out_data_d;
  logic               out_err_d;

  // ---------------------------------------------------------------- decode
  assign req_word = addr[BANK_LSB-1:2];
  assign req_bank = addr[BANK_LSB +: BANK_W];
  assign mapped   = (addr[ADDR_W-1:BANK_LSB+BANK_W] == '0) && (int'(req_bank) < NUM_BANKS);
  assign unused_addr_lsbs = ^addr[1:0];

  // ---------------------------------------------------------------- clear engine
  assign clr_start = (state_q == READY) && clear_start;

  periph_sram_clear_seq #(
    .BUSY_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk  (clk),
    .rst_n(rst_n),
    .start(clr_start),
    .cnt  (clr_cnt),
    .busy (clr_busy),
    .done (clr_done)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      READY:   if (clear_start) state_d = CLEAR;
      CLEAR:   if (clr_done)    state_d = READY;
      default: state_d = state_q;
    endcase
  end

  // Macro bus is combinational from the accepted request; idle cycles replay
  // the last driven values so the shared bus does not toggle needlessly.
  always_comb begin
    gnt        = (state_q == READY);
    clear_busy = (state_q == CLEAR);
    accept     = req && gnt;
    bus_d      = bus_q;
    men_c      = '0;
    if (state_q == CLEAR) begin
      bus_d = '{addr: clr_cnt, bm: '1, din: '0, wen: 1'b1, ren: 1'b0};
      men_c = '1;
    end else if (accept) begin
      bus_d = '{addr: req_word, bm: be_to_bm(be), din: wdata, wen: we, ren: !we};
      for (int i = 0; i < NUM_BANKS; i++) begin
        men_c[i] = mapped && (req_bank == BANK_W'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_q <= '0;
    end else begin
      bus_q <= bus_d;
    end
  end

  // NOTE: macro contents have no reset; the clear engine zero-fills them instead,
  // and the enables are held low while rst_n is asserted so the macros stay idle.
  assign sram_men  = rst_n ? men_c : '0;
  assign sram_addr = bus_d.addr;
  assign sram_bm   = bus_d.bm;
  assign sram_din  = bus_d.din;
  assign sram_wen  = bus_d.wen;
  assign sram_ren  = bus_d.ren;

  // ---------------------------------------------------------------- response
  always_comb begin
    rsp_d = '{valid: accept, err: accept && !mapped, we: we, bank: req_bank};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q <= rsp_d;
    end
  end

  always_comb begin
    rd_bank = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rsp_q.bank == BANK_W'(i)) begin
        rd_bank = sram_dout[i*WORD_W +: WORD_W];
      end
    end
    out_valid_d = rsp_q.valid;
    out_data_d  = '0;
    out_err_d   = 1'b0;
    if (rsp_q.valid) begin
      if (rsp_q.err) begin
        out_data_d = ERR_DATA;
        out_err_d  = 1'b1;
      end else if (!rsp_q.we) begin
        out_data_d = rd_bank;
      end
    end
  end

  // The optional output stage must capture macro DOUT in the response cycle,
  // before a following back-to-back read overwrites it.
  if (OUT_REG) begin : g_out_reg
    logic              out_valid_q;
    logic [WORD_W-1:0] out_data_q;
    logic              out_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
        out_err_q   <= 1'b0;
      end else begin
        out_valid_q <= out_valid_d;
        out_data_q  <= out_data_d;
        out_err_q   <= out_err_d;
      end
    end

    assign rvalid = out_valid_q;
    assign rdata  = out_data_q;
    assign err    = out_err_q;
  end else begin : g_out_comb
    assign rvalid = out_valid_d;
    assign rdata  = out_data_d;
    assign err    = out_err_d;
  end

endmodule

// File: tb/tb_periph_sram_ctrl.sv
// Directed bench: two controllers (OUT_REG = 0 and 1) share stimulus, each
// talking to its own behavioural model of seven 1024x32 macros.
module tb_periph_sram_ctrl;

  localparam int NB = 7;

  logic clk = 1'b0;
  logic rst_n;
  logic req, we, clear_start;
  logic [3:0]  be;
  logic [23:0] addr;
  logic [31:0] wdata;

  logic [1:0]            gnt_w, rvalid_w, err_w, busy_w, wen_w, ren_w;
  logic [1:0][31:0]      rdata_w, bm_w, din_w;
  logic [1:0][9:0]       saddr_w;
  logic [1:0][NB-1:0]    men_w;
  logic [1:0][NB*32-1:0] dout_w = '0;

  logic [31:0] mem [2][NB][1024];
  logic        seeded = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  periph_sram_ctrl #(.NUM_BANKS(NB), .OUT_REG(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt_w[0]), .rvalid(rvalid_w[0]), .rdata(rdata_w[0]), .err(err_w[0]),
    .clear_start(clear_start), .clear_busy(busy_w[0]),
    .sram_addr(saddr_w[0]), .sram_bm(bm_w[0]), .sram_din(din_w[0]),
    .sram_wen(wen_w[0]), .sram_ren(ren_w[0]), .sram_men(men_w[0]), .sram_dout(dout_w[0])
  );

  periph_sram_ctrl #(.NUM_BANKS(NB), .OUT_REG(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .be(be), .addr(addr), .wdata(wdata),
    .gnt(gnt_w[1]), .rvalid(rvalid_w[1]), .rdata(rdata_w[1]), .err(err_w[1]),
    .clear_start(clear_start), .clear_busy(busy_w[1]),
    .sram_addr(saddr_w[1]), .sram_bm(bm_w[1]), .sram_din(din_w[1]),
    .sram_wen(wen_w[1]), .sram_ren(ren_w[1]), .sram_men(men_w[1]), .sram_dout(dout_w[1])
  );

  // Macro model: bit-masked write, registered read, DOUT holds when not reading.
  // Contents start as garbage so the clear engine has something to erase.
  always @(posedge clk) begin
    if (!seeded) begin
      for (int d = 0; d < 2; d++)
        for (int b = 0; b < NB; b++)
          for (int w = 0; w < 1024; w++)
            mem[d][b][w] <= 32'hDEAD_0000 | 32'(w);
      seeded <= 1'b1;
    end else begin
      for (int d = 0; d < 2; d++)
        for (int b = 0; b < NB; b++)
          if (men_w[d][b]) begin
            if (wen_w[d])
              mem[d][b][saddr_w[d]] <= (mem[d][b][saddr_w[d]] & ~bm_w[d]) | (din_w[d] & bm_w[d]);
            if (ren_w[d])
              dout_w[d][b*32 +: 32] <= mem[d][b][saddr_w[d]];
          end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // One isolated access; checks the bus in the request cycle and both DUTs' responses.
  task automatic xfer(input string tag, input logic we_i, input logic [3:0] be_i,
                      input logic [23:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err,
                      input logic [NB-1:0] exp_men, input logic [31:0] exp_bm);
    @(posedge clk); #1;
    req = 1'b1; we = we_i; be = be_i; addr = a; wdata = wd;
    @(negedge clk);
    check({tag, ".gnt"}, gnt_w[0], 1);
    check({tag, ".men"}, men_w[0], exp_men);
    check({tag, ".bm"},  bm_w[0], exp_bm);
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check({tag, ".rv0"},   rvalid_w[0], 1);
    check({tag, ".rd0"},   rdata_w[0], exp_rd);
    check({tag, ".err0"},  err_w[0], exp_err);
    check({tag, ".rv1e"},  rvalid_w[1], 0);
    check({tag, ".idle"},  men_w[0], 0);
    @(negedge clk);
    check({tag, ".rv0o"},  rvalid_w[0], 0);
    check({tag, ".rd0o"},  rdata_w[0], 0);
    check({tag, ".rv1"},   rvalid_w[1], 1);
    check({tag, ".rd1"},   rdata_w[1], exp_rd);
    check({tag, ".err1"},  err_w[1], exp_err);
  endtask

  // Counts negedges with gnt low until gnt rises (bounded); optionally pokes
  // clear_start mid-clear and checks the clear bus on the first and last word.
  task automatic wait_ready(input int poke, input bit chk_bus, output int n, output bit rv_seen);
    n = 0;
    rv_seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (gnt_w[0]) break;
      if (rvalid_w[0] || rvalid_w[1]) rv_seen = 1'b1;
      if (chk_bus && (n == 0 || n == 1023)) begin
        check($sformatf("clr.addr%0d", n), saddr_w[0], n);
        check($sformatf("clr.men%0d", n), men_w[0], {NB{1'b1}});
        check($sformatf("clr.ctl%0d", n), {wen_w[0], ren_w[0]}, 2'b10);
        check($sformatf("clr.bm%0d", n), bm_w[0], 32'hFFFF_FFFF);
        check($sformatf("clr.din%0d", n), din_w[0], 0);
      end
      n++;
      @(posedge clk); #1;
      clear_start = (n == poke);
    end
    clear_start = 1'b0;
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  initial begin
    int  n;
    bit  rv;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = '0; wdata = '0; clear_start = 1'b0;

    // 1. reset values, full clear after reset, then a first read
    repeat (3) @(negedge clk);
    check("rst.gnt",  gnt_w[0], 0);
    check("rst.busy", busy_w[0], 1);
    check("rst.rv",   {rvalid_w[0], err_w[0]}, 0);
    check("rst.rd",   rdata_w[0], 0);
    check("rst.men",  men_w[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(-1, 1'b1, n, rv);
    check("clr1.cycles", n, 1024);
    check("clr1.busy",   busy_w[0], 0);
    xfer("rd404", 1'b0, 4'hF, 24'h000404, 32'h0, 32'h0, 1'b0, 7'b000_0001, 32'hFFFF_FFFF);

    // 2. byte-masked write to bank 3, read back
    xfer("wr3008", 1'b1, 4'b0101, 24'h003008, 32'hA5A5_A5A5, 32'h0, 1'b0, 7'b000_1000, 32'h00FF_00FF);
    xfer("rd3008", 1'b0, 4'hF, 24'h003008, 32'h0, 32'h00A5_00A5, 1'b0, 7'b000_1000, 32'hFFFF_FFFF);

    // 3. preload word 5 of every bank, then read all banks back-to-back
    for (int i = 0; i < NB; i++)
      xfer($sformatf("pre%0d", i), 1'b1, 4'hF, 24'(i << 12) | 24'h000014, pat(i),
           32'h0, 1'b0, 7'(1 << i), 32'hFFFF_FFFF);
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      if (c < NB) begin
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 24'(c << 12) | 24'h000014;
      end else begin
        req = 1'b0;
      end
      @(negedge clk);
      check($sformatf("b2b.rv0.%0d", c), rvalid_w[0], (c >= 1 && c <= NB) ? 1 : 0);
      if (c >= 1 && c <= NB) check($sformatf("b2b.rd0.%0d", c), rdata_w[0], pat(c - 1));
      check($sformatf("b2b.rv1.%0d", c), rvalid_w[1], (c >= 2 && c <= NB + 1) ? 1 : 0);
      if (c >= 2 && c <= NB + 1) check($sformatf("b2b.rd1.%0d", c), rdata_w[1], pat(c - 2));
      @(posedge clk); #1;
    end

    // be == 0 write: normal response, no change
    xfer("wrbe0", 1'b1, 4'h0, 24'h001014, 32'hFFFF_FFFF, 32'h0, 1'b0, 7'b000_0010, 32'h0);
    xfer("rdbe0", 1'b0, 4'hF, 24'h001014, 32'h0, pat(1), 1'b0, 7'b000_0010, 32'hFFFF_FFFF);

    // 4. unmapped addresses: error response, writes dropped
    xfer("rd7000",  1'b0, 4'hF, 24'h007000, 32'h0, 32'hBADC_0DE5, 1'b1, 7'b0, 32'hFFFF_FFFF);
    xfer("rd10000", 1'b0, 4'hF, 24'h010000, 32'h0, 32'hBADC_0DE5, 1'b1, 7'b0, 32'hFFFF_FFFF);
    xfer("wr7000",  1'b1, 4'hF, 24'h007000, 32'hFFFF_FFFF, 32'hBADC_0DE5, 1'b1, 7'b0, 32'hFFFF_FFFF);
    xfer("wr10000", 1'b1, 4'hF, 24'h010000, 32'hFFFF_FFFF, 32'hBADC_0DE5, 1'b1, 7'b0, 32'hFFFF_FFFF);
    xfer("rd0000",  1'b0, 4'hF, 24'h000000, 32'h0, 32'h0, 1'b0, 7'b000_0001, 32'hFFFF_FFFF);
    xfer("rd6000",  1'b0, 4'hF, 24'h006000, 32'h0, 32'h0, 1'b0, 7'b100_0000, 32'hFFFF_FFFF);

    // 5. clear_start coincident with a read; in-flight response keeps old data
    xfer("wr1010", 1'b1, 4'hF, 24'h001010, 32'h1234_5678, 32'h0, 1'b0, 7'b000_0010, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; be = 4'hF; addr = 24'h001010; clear_start = 1'b1;
    @(negedge clk);
    check("cs.gnt", gnt_w[0], 1);
    @(posedge clk); #1;
    req = 1'b0; clear_start = 1'b0;
    @(negedge clk);
    check("cs.rv0",  rvalid_w[0], 1);
    check("cs.rd0",  rdata_w[0], 32'h1234_5678);
    check("cs.gnt0", gnt_w[0], 0);
    check("cs.busy", busy_w[0], 1);
    @(negedge clk);
    check("cs.rv1", rvalid_w[1], 1);
    check("cs.rd1", rdata_w[1], 32'h1234_5678);
    wait_ready(100, 1'b0, n, rv);
    check("clr2.cycles", n + 2, 1024);
    xfer("rd1010c", 1'b0, 4'hF, 24'h001010, 32'h0, 32'h0, 1'b0, 7'b000_0010, 32'hFFFF_FFFF);

    // 6. reset at clear word 500 restarts the clear from word 0
    xfer("wr1010b", 1'b1, 4'hF, 24'h001010, 32'h0000_0055, 32'h0, 1'b0, 7'b000_0010, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    clear_start = 1'b1;
    @(posedge clk); #1;
    clear_start = 1'b0;
    repeat (500) @(posedge clk);
    @(negedge clk);
    check("mid.addr", saddr_w[0], 500);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid.rst.gnt", gnt_w[0], 0);
    check("mid.rst.men", men_w[0], 0);
    check("mid.rst.rv",  {rvalid_w[0], rvalid_w[1]}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_ready(-1, 1'b1, n, rv);
    check("clr3.cycles", n, 1024);
    check("clr3.rv",     rv, 0);
    xfer("rd1010r", 1'b0, 4'hF, 24'h001010, 32'h0, 32'h0, 1'b0, 7'b000_0010, 32'hFFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/periph_sram_ctrl.md
Name: periph_sram_ctrl

Overview:
Controller between the peripheral bus (REQ/GNT/RVALID protocol from peripheral_wrapper) and a row of IHP 1024x32 SRAM macro wrappers.
- Decodes bank and word address, drives the shared macro bus and per-bank enables, and muxes read data back.
- Returns an error response for unmapped addresses.
- Contains a clear engine that zero-fills every bank after reset or on command; the bus is stalled via GNT while clearing.

Parameters:
NUM_BANKS, 7, number of attached 1024x32 macros (1..8)
OUT_REG, 0, 1 = register RDATA/ERR (response latency 2 instead of 1)
CLEAR_ON_RESET, 1, 1 = enter CLEAR after reset, 0 = enter READY
ERR_DATA, 32'hBADC0DE5, RDATA value returned on an error response

Ports:
clk  in  1  clock
rst_n  in  1  reset
req  in  1  bus request
we  in  1  1 = write, 0 = read
be  in  4  byte enables
addr  in  24  byte address
wdata  in  32  write data
gnt  out  1  grant; request accepted when req && gnt
rvalid  out  1  response valid, one pulse per accepted request
rdata  out  32  read data
err  out  1  error flag, qualified by rvalid
clear_start  in  1  pulse requesting a full clear
clear_busy  out  1  high while in CLEAR
sram_addr  out  10  shared word address
sram_bm  out  32  bit mask, each be bit replicated x8
sram_din  out  32  shared write data
sram_wen  out  1  write enable
sram_ren  out  1  read enable
sram_men  out  NUM_BANKS  per-bank macro enable
sram_dout  in  NUM_BANKS*32  bank read data, bank i at [32i+31:32i]

Behaviour:
Clocking and reset:
- Single clock. rst_n is asynchronous and active-low.
- Reset values: state = CLEAR if CLEAR_ON_RESET else READY; clear counter = 0; gnt = 0 in CLEAR; rvalid = 0; err = 0; rdata = 0; sram_men = 0; clear_busy = CLEAR_ON_RESET.

FSM (states CLEAR, READY):
- gnt = (state == READY), combinational.
- READY + clear_start -> CLEAR on the next edge. If req is also high that cycle, the request is still accepted and answered normally.
- clear_start while in CLEAR is ignored.

CLEAR:
- 10-bit counter runs 0..1023, one word per cycle.
- Each cycle: all sram_men = 1, sram_wen = 1, sram_ren = 0, sram_bm = all ones, sram_din = 0, sram_addr = counter.
- At counter == 1023 -> READY; gnt rises the following cycle.
- A full clear holds gnt low for exactly 1024 cycles.
- Reset asserted mid-clear restarts the clear from word 0.

Decode (READY, on accept):
- word = addr[11:2]; bank = addr[14:12].
- Mapped iff addr[23:15] == 0 and bank < NUM_BANKS.
- Mapped request:
  - sram_men[bank] = 1, all other men bits = 0.
  - sram_wen = we, sram_ren = !we.
  - sram_addr = word, sram_din = wdata.
  - sram_bm = {{8{be[3]}}, ..., {8{be[0]}}}.
- Unmapped request: all men = 0, so writes are dropped.
- addr[1:0] is ignored.
- A write with be == 0 is performed with mask 0 (no change) and gets a normal response.
- No accept: all men = 0; other macro outputs are don't-care but held stable.

Response:
- One response per accept, in order.
- Latency 1 + OUT_REG cycles after the accept edge.
- Throughput of one request per cycle, back-to-back, with no bubbles.
- Bank select and the err/we flags are registered at accept.
- Read: rdata = sram_dout of the registered bank.
- Write: rdata = 0.
- Error: err = 1 and rdata = ERR_DATA.
- rdata = 0 and err = 0 whenever rvalid = 0.
- A response in flight when CLEAR is entered is still delivered with pre-clear data. Clear writes use ren = 0, so macro DOUT holds.

Decomposition:
- Package periph_sram_pkg:
  - SRAM_DEPTH = 1024, SRAM_AW = 10, WORD_W = 32, BANK_LSB = 12, BANK_W = 3
  - state_e {CLEAR, READY}
  - default ERR_DATA
  - be-to-bitmask function
- Sub-module periph_sram_clear_seq: counter, busy flag and done pulse, driven by start/reset.

Test Plan:
1. Reset with CLEAR_ON_RESET = 1 -> gnt = 0 for 1024 cycles, clear_busy falls, gnt = 1; a read of 0x000404 then returns rdata = 0, err = 0, one cycle later.
2. Write 0x003008 = 0xA5A5A5A5 with be = 4'b0101, then read it back (bank 3) -> rdata = 0x00A500A5 (on a cleared bank); only sram_men[3] pulses.
3. Back-to-back reads of banks 0..6 every cycle -> seven consecutive rvalid pulses, in order, with the correct data. Repeat with OUT_REG = 1 -> latency 2, same data.
4. Access to 0x007000 (bank 7, NUM_BANKS = 7) and to 0x010000 -> rvalid with err = 1, rdata = 0xBADC0DE5; a write to either address leaves all banks unchanged.
5. clear_start coincident with a read of a word holding 0x12345678 -> response 0x12345678, then 1024 stall cycles, then the same word reads 0.
6. rst_n asserted at clear word 500 and released -> counter restarts at 0; gnt stays low a full 1024 cycles; rvalid = 0 throughout.
